// File: rtl/bus_cycle_pkg.sv
// Shared types and helpers for the 6809 bus-cycle controller.
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    HOLD  = 2'd3
  } bus_state_e;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  // Returned in place of peripheral data when a cycle is aborted.
  localparam logic [MAX_DATA_WIDTH-1:0] ERR_DATA_ONES = {MAX_DATA_WIDTH{1'b1}};

  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_if.sv
// CPU-side 6809 bus signals of the bus-cycle controller.
interface bus_cycle_controller_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_E;
  logic                  i_Q;
  logic                  i_RW;
  logic [ADDR_WIDTH-1:0] i_ADDRESS_BUS;
  logic [DATA_WIDTH-1:0] i_DATA;
  logic [DATA_WIDTH-1:0] o_DATA;
  logic                  o_DATA_OE;
  logic                  o_MRDY;
  logic                  o_DBEN;

  modport master (
    output i_E, i_Q, i_RW, i_ADDRESS_BUS, i_DATA,
    input  o_DATA, o_DATA_OE, o_MRDY, o_DBEN
  );

  modport slave (
    input  i_E, i_Q, i_RW, i_ADDRESS_BUS, i_DATA,
    output o_DATA, o_DATA_OE, o_MRDY, o_DBEN
  );
endinterface

// File: rtl/bus_edge_sync.sv
// Two-flop synchroniser for an asynchronous CPU clock phase with a
// one-clk edge pulse on the synchronised value (rise or fall selectable).
module bus_edge_sync #(
  parameter bit DETECT_RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift chain: metastability stage, stable stage, previous-value stage.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge pulse.
  always_comb begin
    if (DETECT_RISE) begin
      pulse_o = sync_q & ~prev_q;
    end else begin
      pulse_o = ~sync_q & prev_q;
    end
  end
endmodule

// File: rtl/bus_cycle_controller.sv
// 6809 bus-cycle engine: window decode, MRDY stretching with per-region waits
// and peripheral ready, read-data return, write capture and hung-cycle abort.
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_WIDTH  = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {16'hF000, 16'hA000, 16'h1000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {16'hF000, 16'hE000, 16'hF000, 16'hF000},
  parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAIT = {4'd2, 4'd1, 4'd0, 4'd0},
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              i_RESET,
  bus_cycle_controller_if.slave             bus,
  output logic [NUM_REGIONS-1:0]            o_region_ce,
  input  logic [NUM_REGIONS-1:0]            i_region_ready,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] i_region_rdata,
  output logic [DATA_WIDTH-1:0]             o_wdata,
  output logic                              o_wr_strobe,
  output logic                              o_bus_error,
  output logic                              o_unmapped
);
  localparam int unsigned REG_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  bus_state_e             state_q, state_d;
  logic [REG_W-1:0]       idx_q, idx_d, hit_idx_s;
  logic                   rw_q, rw_d;
  logic [WAIT_WIDTH-1:0]  wait_q, wait_d, hit_wait_s;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   hit_s, q_rise_s, e_fall_s, timeout_s, sel_ready_s;
  logic [DATA_WIDTH-1:0]  sel_rdata_s;

  logic                   mrdy_q, mrdy_d, dben_q, dben_d, oe_q, oe_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d, wdata_q, wdata_d;
  logic [NUM_REGIONS-1:0] ce_q, ce_d;
  logic                   strobe_q, strobe_d, err_q, err_d, unmapped_q, unmapped_d;

  bus_edge_sync #(.DETECT_RISE(1'b1)) u_q_sync (
    .clk(clk), .rst_n(i_RESET), .async_i(bus.i_Q), .pulse_o(q_rise_s)
  );

  bus_edge_sync #(.DETECT_RISE(1'b0)) u_e_sync (
    .clk(clk), .rst_n(i_RESET), .async_i(bus.i_E), .pulse_o(e_fall_s)
  );

  // Priority window decode: the first matching region from index 0 upward wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (!hit_s && ((bus.i_ADDRESS_BUS & REGION_MASK[slice_lsb(r, ADDR_WIDTH) +: ADDR_WIDTH])
                     == REGION_BASE[slice_lsb(r, ADDR_WIDTH) +: ADDR_WIDTH])) begin
        hit_s     = 1'b1;
        hit_idx_s = REG_W'(r);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Per-region selections for the decoded and the active cycle.
  always_comb begin
    hit_wait_s  = REGION_WAIT[slice_lsb(32'(hit_idx_s), WAIT_WIDTH) +: WAIT_WIDTH];
    sel_ready_s = i_region_ready[idx_q];
    sel_rdata_s = i_region_rdata[slice_lsb(32'(idx_q), DATA_WIDTH) +: DATA_WIDTH];
  end

  // State and cycle-context registers.
  always_ff @(posedge clk or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rw_q    <= 1'b1;
      wait_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; the timeout check outranks peripheral ready.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rw_d      = rw_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (q_rise_s && hit_s) begin
          state_d = WAIT;
          idx_d   = hit_idx_s;
          rw_d    = bus.i_RW;
          wait_d  = hit_wait_s;
          tmo_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        wait_d = (wait_q != '0) ? (wait_q - WAIT_WIDTH'(1)) : '0;
        tmo_d  = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_LAST) begin
          timeout_s = 1'b1;
          state_d   = READY;
        end else if ((wait_q == '0) && sel_ready_s) begin
          state_d   = READY;
        end else begin
          state_d   = WAIT;
        end
      end
      READY: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (e_fall_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, registered below so every port comes straight from a flop.
  always_comb begin
    mrdy_d = (state_d != WAIT);
    dben_d = (state_d == IDLE);
    ce_d   = '0;
    if (state_d != IDLE) begin
      ce_d[idx_d] = 1'b1;
    end else begin
      ce_d = '0;
    end

    data_d = data_q;
    if ((state_q == WAIT) && (state_d == READY) && rw_q) begin
      oe_d   = 1'b1;
      data_d = timeout_s ? ERR_DATA_ONES[DATA_WIDTH-1:0] : sel_rdata_s;
    end else if (state_d == IDLE) begin
      oe_d   = 1'b0;
    end else begin
      oe_d   = oe_q;
    end

    if ((state_q == HOLD) && e_fall_s && !rw_q) begin
      wdata_d  = bus.i_DATA;
      strobe_d = 1'b1;
    end else begin
      wdata_d  = wdata_q;
      strobe_d = 1'b0;
    end

    err_d      = err_q | timeout_s;
    unmapped_d = (state_q == IDLE) && q_rise_s && !hit_s;
  end

  // Output registers; reset releases MRDY immediately.
  always_ff @(posedge clk or negedge i_RESET) begin
    if (!i_RESET) begin
      mrdy_q     <= 1'b1;
      dben_q     <= 1'b1;
      oe_q       <= 1'b0;
      data_q     <= '0;
      ce_q       <= '0;
      wdata_q    <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      unmapped_q <= 1'b0;
    end else begin
      mrdy_q     <= mrdy_d;
      dben_q     <= dben_d;
      oe_q       <= oe_d;
      data_q     <= data_d;
      ce_q       <= ce_d;
      wdata_q    <= wdata_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign bus.o_MRDY    = mrdy_q;
  assign bus.o_DBEN    = dben_q;
  assign bus.o_DATA_OE = oe_q;
  assign bus.o_DATA    = data_q;
  assign o_region_ce   = ce_q;
  assign o_wdata       = wdata_q;
  assign o_wr_strobe   = strobe_q;
  assign o_bus_error   = err_q;
  assign o_unmapped    = unmapped_q;
endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller: directed and random 6809
// cycles checked against a cycle-level model of decode, stretch and data return.
module tb_bus_cycle_controller;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ce;
  logic [3:0]  ready_v;
  logic [31:0] rdata_v;
  logic [7:0]  wdata;
  logic        strobe, berr, unm;

  int n_checks = 0;
  int n_errors = 0;
  bit err_model = 1'b0;

  logic [15:0] base_t [4] = '{16'h0000, 16'h1000, 16'hA000, 16'hF000};
  logic [15:0] mask_t [4] = '{16'hF000, 16'hF000, 16'hE000, 16'hF000};
  int          wait_t [4] = '{0, 0, 1, 2};

  bus_cycle_controller_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_if ();

  bus_cycle_controller dut (
    .clk            (clk),
    .i_RESET        (rst_n),
    .bus            (bus_if.slave),
    .o_region_ce    (ce),
    .i_region_ready (ready_v),
    .i_region_rdata (rdata_v),
    .o_wdata        (wdata),
    .o_wr_strobe    (strobe),
    .o_bus_error    (berr),
    .o_unmapped     (unm)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int region_of(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & mask_t[i]) == base_t[i]) return i;
    end
    return -1;
  endfunction

  // d: WAIT clk on which the selected ready rises (0 = already high, -1 = never)
  task automatic run_cycle(input logic [15:0] addr, input bit rw, input logic [7:0] wd, input int d);
    int r, n_exp, lowcnt, unm_cnt, strobe_cnt, oe_bad, ce_bad, dben_bad;
    bit to, released;
    logic [7:0] rd [4];
    logic [7:0] got_wdata;
    logic [3:0] exp_ce;
    r = region_of(addr);
    n_exp = 0; to = 1'b0; lowcnt = 0; unm_cnt = 0; strobe_cnt = 0;
    oe_bad = 0; ce_bad = 0; dben_bad = 0; released = 1'b0; got_wdata = 8'h00;
    for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
    rdata_v = {rd[3], rd[2], rd[1], rd[0]};
    ready_v = 4'($urandom);
    exp_ce  = (r >= 0) ? 4'(1 << r) : 4'd0;
    if (r >= 0) begin
      ready_v[r] = (d == 0);
      if (d < 0) n_exp = TIMEOUT;
      else n_exp = (d > wait_t[r] + 1) ? d : wait_t[r] + 1;
      if (n_exp >= TIMEOUT) n_exp = TIMEOUT;
      to = (n_exp == TIMEOUT);
    end
    bus_if.i_ADDRESS_BUS = addr;
    bus_if.i_RW = rw;
    bus_if.i_DATA = wd;
    @(negedge clk);
    bus_if.i_Q = 1'b1;
    bus_if.i_E = 1'b1;
    for (int c = 0; c < ((r < 0) ? 10 : 120) && !released; c++) begin
      @(negedge clk);
      if (unm) unm_cnt++;
      if (bus_if.o_DATA_OE && !rw) oe_bad++;
      if (r < 0 && (ce !== 4'd0 || !bus_if.o_DBEN)) begin
        ce_bad++;
        dben_bad++;
      end
      if (!bus_if.o_MRDY) begin
        lowcnt++;
        if (ce !== exp_ce) ce_bad++;
        if (bus_if.o_DBEN) dben_bad++;
        if (r >= 0 && d > 0 && lowcnt == d) ready_v[r] = 1'b1;
      end else if (lowcnt > 0) begin
        released = 1'b1;
      end
    end
    if (r >= 0) begin
      err_model = err_model | to;
      check_eq("release", 32'(released), 32'd1);
      check_eq("mrdy_low_clks", lowcnt, n_exp);
      check_eq("ce_dben_wait", ce_bad + dben_bad, 0);
      check_eq("ce_ready", 32'(ce), 32'(exp_ce));
      check_eq("dben_ready", 32'(bus_if.o_DBEN), 32'd0);
      check_eq("oe_ready", 32'(bus_if.o_DATA_OE), 32'(rw));
      if (rw) check_eq("rdata", 32'(bus_if.o_DATA), to ? 32'hFF : 32'(rd[r]));
      check_eq("bus_error", 32'(berr), 32'(err_model));
      repeat (2) @(negedge clk);
      check_eq("oe_hold", 32'(bus_if.o_DATA_OE), 32'(rw));
      bus_if.i_E = 1'b0;
      bus_if.i_Q = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (strobe) begin
          strobe_cnt++;
          got_wdata = wdata;
        end
        if (bus_if.o_DATA_OE && !rw) oe_bad++;
      end
      check_eq("wr_strobe_cnt", strobe_cnt, rw ? 0 : 1);
      if (!rw) check_eq("wdata", 32'(got_wdata), 32'(wd));
      check_eq("ce_idle", 32'(ce), 32'd0);
      check_eq("dben_idle", 32'(bus_if.o_DBEN), 32'd1);
      check_eq("oe_idle", 32'(bus_if.o_DATA_OE), 32'd0);
      check_eq("oe_on_write", oe_bad, 0);
      check_eq("no_unmapped", unm_cnt, 0);
    end else begin
      check_eq("unmapped_pulse", unm_cnt, 1);
      check_eq("mrdy_unmapped", lowcnt, 0);
      check_eq("ce_dben_unmapped", ce_bad + dben_bad, 0);
      bus_if.i_E = 1'b0;
      bus_if.i_Q = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic reset_mid_wait();
    int lowcnt;
    lowcnt = 0;
    ready_v = 4'd0;
    bus_if.i_ADDRESS_BUS = 16'hF000;
    bus_if.i_RW = 1'b1;
    @(negedge clk);
    bus_if.i_Q = 1'b1;
    bus_if.i_E = 1'b1;
    for (int c = 0; c < 20 && lowcnt < 3; c++) begin
      @(negedge clk);
      if (!bus_if.o_MRDY) lowcnt++;
    end
    check_eq("reached_wait", lowcnt, 3);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mrdy", 32'(bus_if.o_MRDY), 32'd1);
    check_eq("rst_ce", 32'(ce), 32'd0);
    check_eq("rst_oe", 32'(bus_if.o_DATA_OE), 32'd0);
    check_eq("rst_dben", 32'(bus_if.o_DBEN), 32'd1);
    check_eq("rst_berr", 32'(berr), 32'd0);
    err_model = 1'b0;
    bus_if.i_Q = 1'b0;
    bus_if.i_E = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] addr;
    int sel, k, d;
    rst_n = 1'b1;
    bus_if.i_E = 1'b0;
    bus_if.i_Q = 1'b0;
    bus_if.i_RW = 1'b1;
    bus_if.i_ADDRESS_BUS = 16'h0000;
    bus_if.i_DATA = 8'h00;
    ready_v = 4'd0;
    rdata_v = 32'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_mrdy", 32'(bus_if.o_MRDY), 32'd1);
    check_eq("reset_dben", 32'(bus_if.o_DBEN), 32'd1);
    check_eq("reset_oe", 32'(bus_if.o_DATA_OE), 32'd0);
    check_eq("reset_data", 32'(bus_if.o_DATA), 32'd0);
    check_eq("reset_ce", 32'(ce), 32'd0);
    check_eq("reset_wdata", 32'(wdata), 32'd0);
    check_eq("reset_strobe", 32'(strobe), 32'd0);
    check_eq("reset_berr", 32'(berr), 32'd0);
    check_eq("reset_unmapped", 32'(unm), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_cycle(16'h0010, 1'b1, 8'h00, 0);
    run_cycle(16'hF123, 1'b1, 8'h00, 5);
    run_cycle(16'hA004, 1'b0, 8'h3C, 0);
    run_cycle(16'h1000, 1'b1, 8'h00, -1);
    run_cycle(16'h8000, 1'b1, 8'h00, 0);
    run_cycle(16'h0020, 1'b1, 8'h00, 0);
    run_cycle(16'hF456, 1'b0, 8'hA5, 1);
    reset_mid_wait();
    run_cycle(16'hF000, 1'b1, 8'h00, 0);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 4);
      if (sel < 4) addr = base_t[sel] | (16'($urandom) & ~mask_t[sel]);
      else addr = 16'($urandom);
      k = $urandom_range(0, 19);
      d = (k == 0) ? -1 : ((k < 8) ? 0 : $urandom_range(1, 10));
      run_cycle(addr, 1'($urandom_range(0, 1)), 8'($urandom), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
Parametrised 6809 bus-cycle engine that replaces the fixed SRAM/flash/UART decode, data-bus mux and MRDY wiring in the adapter top. It decodes the address into NUM_REGIONS programmable windows and stretches the CPU via MRDY for per-region wait states plus peripheral ready. It returns read data from the selected region, captures write data with a one-cycle strobe, and aborts hung peripherals with a timeout.

Parameters:
NUM_REGIONS, 4, number of decoded address windows; index 0 has highest priority
ADDR_WIDTH, 16, CPU address width
DATA_WIDTH, 8, CPU data width
REGION_BASE, {16'hF000,16'hA000,16'h1000,16'h0000}, packed per-region base address; region r occupies slice r
REGION_MASK, {16'hF000,16'hE000,16'hF000,16'hF000}, packed per-region compare mask; hit when (addr & mask) == base
REGION_WAIT, {4'd2,4'd1,4'd0,4'd0}, packed per-region minimum wait count in clk cycles, WAIT_WIDTH bits each
WAIT_WIDTH, 4, width of one wait field
TIMEOUT, 64, max clk cycles MRDY may be held low before abort

Ports:
clk  input  1  internal oscillator clock
i_RESET  input  1  asynchronous active-low reset
i_E  input  1  6809 E, asynchronous
i_Q  input  1  6809 Q, asynchronous
i_RW  input  1  1 = read, 0 = write
i_ADDRESS_BUS  input  ADDR_WIDTH  CPU address
i_DATA  input  DATA_WIDTH  data bus input side
o_DATA  output  DATA_WIDTH  read data to data bus
o_DATA_OE  output  1  drive o_DATA onto data bus
o_MRDY  output  1  low = stretch CPU
o_DBEN  output  1  low while a mapped cycle is active
o_region_ce  output  NUM_REGIONS  one-hot region select
i_region_ready  input  NUM_REGIONS  per-region peripheral ready
i_region_rdata  input  NUM_REGIONS*DATA_WIDTH  per-region read data, packed
o_wdata  output  DATA_WIDTH  captured write data
o_wr_strobe  output  1  one-clk pulse when o_wdata is valid
o_bus_error  output  1  sticky timeout flag; cleared only by reset
o_unmapped  output  1  one-clk pulse when a cycle hits no region

Behaviour:
- Reset (async, i_RESET low) forces: o_MRDY=1, o_DBEN=1, o_DATA_OE=0, o_DATA=0, o_region_ce=0, o_wdata=0, o_wr_strobe=0, o_bus_error=0, o_unmapped=0, state IDLE, all counters 0. Reset asserted mid-cycle releases MRDY immediately.
- E and Q each pass through a 2-FF synchroniser. Edge detect uses the synchronised values. Synchronisation latency is 2 clk; edge pulses are 1 clk wide.
- IDLE: on Q rise, latch address and RW, then evaluate hit. Priority: lowest-index matching region wins.
  - No hit: pulse o_unmapped; stay IDLE.
  - Hit r: next clk set o_region_ce[r]=1, o_DBEN=0 and o_MRDY=0; load wait counter with REGION_WAIT[r] and timeout counter with 0; go to WAIT.
- WAIT: each clk, wait counter decrements (saturating at 0) and timeout counter increments.
  - Leave when wait counter==0 and i_region_ready[r]=1: go to READY.
  - Timeout counter == TIMEOUT-1: set o_bus_error, force read data all-ones, go to READY. Timeout takes priority if it coincides with ready.
  - With REGION_WAIT=0 and ready already high, WAIT lasts exactly 1 clk.
- READY: o_MRDY=1.
  - Read: o_DATA <= selected rdata (or all-ones on timeout); o_DATA_OE=1.
  - Write: no drive.
  - Go to HOLD.
- HOLD: wait for E fall.
  - Write: o_wdata <= i_DATA sampled on the E-fall clk; o_wr_strobe pulses the same clk.
  - Then clear o_region_ce, o_DATA_OE and o_DBEN=1; return to IDLE.
  - A Q rise seen in HOLD is ignored; a new cycle is accepted only from IDLE.
- o_DATA_OE is never 1 while i_RW=0.
- o_region_ce has at most one bit set.
- o_MRDY is low only in WAIT.

Decomposition:
- Shared package bus_cycle_pkg holds: the state enum (IDLE, WAIT, READY, HOLD); a slice-index helper function for the packed parameters; the all-ones error constant.
- Sub-module bus_edge_sync: 2-FF synchroniser plus rise/fall pulse generation; instantiated for i_E and i_Q.

Test Plan:
- Read 0x0010, region0 WAIT=0, ready=1, rdata=0x5A -> ce=0001, MRDY low 1 clk, o_DATA=0x5A with OE until E fall, no error.
- Read 0xF123, WAIT=2, ready held low 5 clk then high, rdata=0xC3 -> MRDY low 5 clk, ce=1000, o_DATA=0xC3.
- Write 0xA004, data 0x3C -> ce=0100, o_wr_strobe one pulse at E fall, o_wdata=0x3C, OE stays 0.
- Read 0x1000, region1 ready never asserts -> MRDY released after 64 clk, o_DATA=0xFF, o_bus_error=1 and remains 1 over following cycles.
- Access 0x8000 -> o_unmapped one pulse, ce=0, MRDY stays 1, DBEN stays 1.
- Assert i_RESET during WAIT of a 0xF000 read -> MRDY=1, ce=0, OE=0 immediately; the next cycle decodes normally after release.
